// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int cXLEN     = 32;
    localparam int cRamDepth = 1024;
    localparam int cRegAw    = 5;

    localparam logic [2:0] cLB  = 3'b000;
    localparam logic [2:0] cLH  = 3'b001;
    localparam logic [2:0] cLW  = 3'b010;
    localparam logic [2:0] cLBU = 3'b100;
    localparam logic [2:0] cLHU = 3'b101;
    localparam logic [2:0] cSB  = 3'b000;
    localparam logic [2:0] cSH  = 3'b001;
    localparam logic [2:0] cSW  = 3'b010;

    typedef enum logic [1:0] {eRspNone, eRspFetch, eRspData} tRspTag;

    typedef struct packed {
        logic              read;
        logic              write;
        logic [cXLEN-1:0]  addr;
        logic [cXLEN-1:0]  data;
        logic [2:0]        opType;
        logic [cRegAw-1:0] rdAddr;
    } tMemOp;

    typedef struct packed {
        logic              dv;
        logic [cRegAw-1:0] rdAddr;
        logic [cXLEN-1:0]  data;
    } tRegOp;

    localparam tRegOp cRegOp = '0;

    typedef struct packed {
        tRspTag            tag;
        logic [1:0]        lane;
        logic [2:0]        opType;
        logic [cRegAw-1:0] rdAddr;
    } tRspInfo;

    localparam tRspInfo cRspNone = '{tag: eRspNone, default: '0};

endpackage

// File: rtl/mem_port_arbiter_load_store_align.sv
// Combinational byte-lane steering: store byte enables / replicated write data,
// and load lane select with sign or zero extension.
module load_store_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0]       iStOp,
    input  logic [1:0]       iStLane,
    input  logic [cXLEN-1:0] iStData,
    output logic [3:0]       oBe,
    output logic [cXLEN-1:0] oWdata,
    input  logic [2:0]       iLdOp,
    input  logic [1:0]       iLdLane,
    input  logic [cXLEN-1:0] iRdata,
    output logic [cXLEN-1:0] oLdData
);

    logic [2*cXLEN-1:0] dbl;
    logic [cXLEN-1:0]   rot;

    always_comb begin
        oBe    = '0;
        oWdata = '0;
        case (iStOp)
            cSB: begin
                oBe    = 4'b0001 << iStLane;
                oWdata = {4{iStData[7:0]}};
            end
            cSH: begin
                oBe    = 4'b0011 << {iStLane[1], 1'b0};
                oWdata = {2{iStData[15:0]}};
            end
            cSW: begin
                oBe    = 4'b1111;
                oWdata = iStData;
            end
            default: ;
        endcase
    end

    // Rotating the doubled word lets an unaligned half wrap around within the word.
    assign dbl = {iRdata, iRdata};
    assign rot = dbl[{iLdLane, 3'b000} +: cXLEN];

    always_comb begin
        oLdData = '0;
        case (iLdOp)
            cLB:  oLdData = {{24{rot[7]}}, rot[7:0]};
            cLH:  oLdData = {{16{rot[15]}}, rot[15:0]};
            cLW:  oLdData = iRdata;
            cLBU: oLdData = {24'h0, rot[7:0]};
            cLHU: oLdData = {16'h0, rot[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port 1-cycle RAM between instruction fetch and ALU data ops.
// Optional MEM_ARB_MISALIGN_TRAP_EN adds oMisalign/oMisalignAddr trap reporting.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter  int pRamDepth     = cRamDepth,
    parameter  int pMaxDataBurst = 4,
    localparam int cAw           = $clog2(pRamDepth)
) (
    input  logic             iClk,
    input  logic             iRstN,
    input  logic             iFetchReq,
    input  logic [cXLEN-1:0] iFetchAddr,
    input  logic             iFetchFlush,
    output logic             oFetchGnt,
    output logic             oInstDv,
    output logic [cXLEN-1:0] oInst,
    input  tMemOp            iMemOp,
    output logic             oMemGnt,
    output tRegOp            oRegOp,
    output logic             oStoreDone,
    output logic             oRamEn,
    output logic             oRamWe,
    output logic [3:0]       oRamBe,
    output logic [cAw-1:0]   oRamAddr,
    output logic [cXLEN-1:0] oRamWdata,
    input  logic [cXLEN-1:0] iRamRdata
`ifdef MEM_ARB_MISALIGN_TRAP_EN
    ,
    output logic             oMisalign,
    output logic [cXLEN-1:0] oMisalignAddr
`endif
);

    localparam logic [3:0] cMaxBurst = 4'(pMaxDataBurst);

    tRspInfo          rsp_q, rsp_d;
    logic [3:0]       burstCnt_q, burstCnt_d;
    logic             instDv_q, storeDone_q;
    logic [cXLEN-1:0] inst_q;
    tRegOp            regOp_q;

    logic             dataReq, fetchReq, fetchWins, fetchGnt, memGnt;
    logic             isWrite, isRead, trap;
    logic [3:0]       stBe;
    logic [cXLEN-1:0] stWdata, ldData;
    logic             unusedBits;

    assign unusedBits = ^{iFetchAddr[cXLEN-1:cAw+2], iFetchAddr[1:0], iMemOp.addr[cXLEN-1:cAw+2]};

    assign dataReq   = iMemOp.read | iMemOp.write;
    assign fetchReq  = iFetchReq & ~iFetchFlush;
    assign fetchWins = fetchReq & (~dataReq | (burstCnt_q == cMaxBurst));
    // Grants are held off while reset is asserted so every output reads 0.
    assign fetchGnt  = iRstN & fetchWins;
    assign memGnt    = iRstN & dataReq & ~fetchWins;

`ifdef MEM_ARB_MISALIGN_TRAP_EN
    logic             misalign_q;
    logic [cXLEN-1:0] misalignAddr_q;
    logic             badAlign;

    assign badAlign = ((iMemOp.opType[1:0] == 2'b01) && iMemOp.addr[0]) ||
                      ((iMemOp.opType == cLW) && (iMemOp.addr[1:0] != 2'b00));
    assign trap = memGnt & badAlign;
`else
    assign trap = 1'b0;
`endif

    assign isWrite = memGnt & iMemOp.write & ~trap;
    assign isRead  = memGnt & ~iMemOp.write & ~trap;

    load_store_align u_align (
        .iStOp   (iMemOp.opType),
        .iStLane (iMemOp.addr[1:0]),
        .iStData (iMemOp.data),
        .oBe     (stBe),
        .oWdata  (stWdata),
        .iLdOp   (rsp_q.opType),
        .iLdLane (rsp_q.lane),
        .iRdata  (iRamRdata),
        .oLdData (ldData)
    );

    always_comb begin
        oRamEn    = fetchGnt | isRead | isWrite;
        oRamWe    = isWrite;
        oRamBe    = isWrite ? stBe : 4'b0000;
        oRamWdata = isWrite ? stWdata : '0;
        oRamAddr  = '0;
        if (fetchGnt)
            oRamAddr = iFetchAddr[cAw+1:2];
        else if (isRead | isWrite)
            oRamAddr = iMemOp.addr[cAw+1:2];
    end

    always_comb begin
        rsp_d = cRspNone;
        if (fetchGnt) begin
            rsp_d.tag = eRspFetch;
        end else if (isRead) begin
            rsp_d.tag    = eRspData;
            rsp_d.lane   = iMemOp.addr[1:0];
            rsp_d.opType = iMemOp.opType;
            rsp_d.rdAddr = iMemOp.rdAddr;
        end
    end

    always_comb begin
        burstCnt_d = burstCnt_q;
        if (fetchGnt || !iFetchReq)
            burstCnt_d = '0;
        else if (memGnt && (burstCnt_q != cMaxBurst))
            burstCnt_d = burstCnt_q + 4'd1;
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            rsp_q       <= cRspNone;
            burstCnt_q  <= '0;
            instDv_q    <= 1'b0;
            inst_q      <= '0;
            regOp_q     <= cRegOp;
            storeDone_q <= 1'b0;
        end else begin
            rsp_q       <= rsp_d;
            burstCnt_q  <= burstCnt_d;
            // A flush seen while the fetch data is on the RAM bus kills delivery.
            instDv_q    <= (rsp_q.tag == eRspFetch) & ~iFetchFlush;
            if (rsp_q.tag == eRspFetch)
                inst_q <= iRamRdata;
            regOp_q.dv  <= (rsp_q.tag == eRspData);
            if (rsp_q.tag == eRspData) begin
                regOp_q.rdAddr <= rsp_q.rdAddr;
                regOp_q.data   <= ldData;
            end
            storeDone_q <= isWrite;
        end
    end

`ifdef MEM_ARB_MISALIGN_TRAP_EN
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            misalign_q     <= 1'b0;
            misalignAddr_q <= '0;
        end else begin
            misalign_q <= trap;
            if (trap)
                misalignAddr_q <= iMemOp.addr;
        end
    end

    assign oMisalign     = misalign_q;
    assign oMisalignAddr = misalignAddr_q;
`endif

    assign oFetchGnt  = fetchGnt;
    assign oMemGnt    = memGnt;
    assign oInstDv    = instDv_q;
    assign oInst      = inst_q;
    assign oRegOp     = regOp_q;
    assign oStoreDone = storeDone_q;

endmodule
